// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
// Holds the sequencer state encoding and the hard-wired zero register specifier.
package pipe_ctrl_pkg;

    localparam int PC_REG_W = 4;

    localparam logic [PC_REG_W-1:0] ZERO_REG = 4'd0;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pipe_ctrl_sat_cnt.sv
// Width-parameterised up-counter that sticks at all-ones, with a synchronous clear
// that takes priority over the increment.
module sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, saturating increment, or hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {W{1'b0}};
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Central sequencer for the 5-stage pipeline: per-register hold/flush controls, PC enable,
// load-use / branch / memory-wait / halt handling, stall statistics and dmem timeout flag.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W      = 4,
    parameter int CNT_W      = 16,
    parameter int DM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_vld,
    input  logic             id_rt_vld,
    input  logic             id_hlt,
    input  logic             ex_dm_rd_en,
    input  logic             ex_rf_we,
    input  logic [REG_W-1:0] ex_wr_reg,
    input  logic             mem_take_br,
    input  logic             mem_dm_req,
    input  logic             dmem_rdy,
    input  logic             imem_rdy,
    input  logic             wb_hlt,
    input  logic             stat_clr,
    output logic             pc_we,
    output logic             pc_sel_alt,
    output logic             if_id_we,
    output logic             id_ex_we,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             mem_err
);

    localparam int WAIT_W = $clog2(DM_TIMEOUT + 1);

    pc_state_e state_q;
    pc_state_e state_d;
    logic      mem_err_q;
    logic      mem_err_d;

    logic pc_we_s, pc_sel_alt_s;
    logic if_id_we_s, id_ex_we_s, ex_mem_we_s, mem_wb_we_s;
    logic if_id_flush_s, id_ex_flush_s, ex_mem_flush_s;
    logic dm_wait_s, dm_frz_s, load_use_s, stall_inc_s;
    logic [WAIT_W-1:0] wait_cnt_s;

    assign dm_wait_s  = mem_dm_req & ~dmem_rdy;
    assign load_use_s = ex_dm_rd_en & ex_rf_we & (ex_wr_reg != REG_W'(ZERO_REG)) &
                        ((id_rs_vld & (id_rs == ex_wr_reg)) |
                         (id_rt_vld & (id_rt == ex_wr_reg)));

    // Control decode and next state by priority: dmem wait, branch, load-use, imem wait, halt
    always_comb begin
        state_d        = state_q;
        pc_we_s        = 1'b1;
        pc_sel_alt_s   = 1'b0;
        if_id_we_s     = 1'b1;
        id_ex_we_s     = 1'b1;
        ex_mem_we_s    = 1'b1;
        mem_wb_we_s    = 1'b1;
        if_id_flush_s  = 1'b0;
        id_ex_flush_s  = 1'b0;
        ex_mem_flush_s = 1'b0;
        case (state_q)
            ST_RUN, ST_DRAIN: begin
                if (dm_wait_s) begin
                    pc_we_s     = 1'b0;
                    if_id_we_s  = 1'b0;
                    id_ex_we_s  = 1'b0;
                    ex_mem_we_s = 1'b0;
                    mem_wb_we_s = 1'b0;
                end else if (mem_take_br) begin
                    pc_sel_alt_s   = 1'b1;
                    if_id_flush_s  = 1'b1;
                    id_ex_flush_s  = 1'b1;
                    ex_mem_flush_s = 1'b1;
                    state_d        = ST_RUN;
                end else if (state_q == ST_DRAIN) begin
                    pc_we_s       = 1'b0;
                    if_id_flush_s = 1'b1;
                    if (wb_hlt) begin
                        state_d = ST_HALTED;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (load_use_s) begin
                    pc_we_s       = 1'b0;
                    if_id_we_s    = 1'b0;
                    id_ex_flush_s = 1'b1;
                end else if (!imem_rdy) begin
                    pc_we_s       = 1'b0;
                    if_id_flush_s = 1'b1;
                end else if (id_hlt) begin
                    pc_we_s       = 1'b0;
                    if_id_flush_s = 1'b1;
                    state_d       = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                pc_we_s     = 1'b0;
                if_id_we_s  = 1'b0;
                id_ex_we_s  = 1'b0;
                ex_mem_we_s = 1'b0;
                mem_wb_we_s = 1'b0;
            end
            default: begin
                state_d     = ST_RUN;
                pc_we_s     = 1'b0;
                if_id_we_s  = 1'b0;
                id_ex_we_s  = 1'b0;
                ex_mem_we_s = 1'b0;
                mem_wb_we_s = 1'b0;
            end
        endcase
    end

    assign dm_frz_s    = dm_wait_s & (state_q != ST_HALTED);
    assign stall_inc_s = ~pc_we_s & (state_q != ST_HALTED);

    // Sticky timeout flag; a statistics clear beats a same-cycle set
    always_comb begin
        mem_err_d = mem_err_q;
        if (stat_clr) begin
            mem_err_d = 1'b0;
        end else if (wait_cnt_s == WAIT_W'(DM_TIMEOUT)) begin
            mem_err_d = 1'b1;
        end else begin
            mem_err_d = mem_err_q;
        end
    end

    // Sequencer state and error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_err_q <= mem_err_d;
        end
    end

    sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (stat_clr),
        .inc_i (stall_inc_s),
        .cnt_o (stall_cnt)
    );

    sat_cnt #(.W(WAIT_W)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (~dm_frz_s),
        .inc_i (dm_frz_s),
        .cnt_o (wait_cnt_s)
    );

    // Controls are forced inactive while reset is asserted, independent of the inputs
    assign pc_we        = rst_n & pc_we_s;
    assign pc_sel_alt   = rst_n & pc_sel_alt_s;
    assign if_id_we     = rst_n & if_id_we_s;
    assign id_ex_we     = rst_n & id_ex_we_s;
    assign ex_mem_we    = rst_n & ex_mem_we_s;
    assign mem_wb_we    = rst_n & mem_wb_we_s;
    assign if_id_flush  = rst_n & if_id_flush_s;
    assign id_ex_flush  = rst_n & id_ex_flush_s;
    assign ex_mem_flush = rst_n & ex_mem_flush_s;
    assign halted       = rst_n & (state_q == ST_HALTED);
    assign mem_err      = mem_err_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; controls are compared as one packed vector
// {pc_we, pc_sel_alt, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_flush, ex_mem_flush, halted}.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  id_rs, id_rt, ex_wr_reg;
    logic        id_rs_vld, id_rt_vld, id_hlt, ex_dm_rd_en, ex_rf_we;
    logic        mem_take_br, mem_dm_req, dmem_rdy, imem_rdy, wb_hlt, stat_clr;
    logic        pc_we, pc_sel_alt, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, halted, mem_err;
    logic [15:0] stall_cnt;
    logic [9:0]  ctl;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [9:0] C_NORM = 10'b1011110000;
    localparam logic [9:0] C_LU   = 10'b0001110100;
    localparam logic [9:0] C_BR   = 10'b1111111110;
    localparam logic [9:0] C_FRZ  = 10'b0000000000;
    localparam logic [9:0] C_IFW  = 10'b0011111000;
    localparam logic [9:0] C_HLT  = 10'b0000000001;

    always #5 clk = ~clk;

    assign ctl = {pc_we, pc_sel_alt, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
                  if_id_flush, id_ex_flush, ex_mem_flush, halted};

    pipe_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_vld(id_rs_vld), .id_rt_vld(id_rt_vld), .id_hlt(id_hlt),
        .ex_dm_rd_en(ex_dm_rd_en), .ex_rf_we(ex_rf_we), .ex_wr_reg(ex_wr_reg),
        .mem_take_br(mem_take_br), .mem_dm_req(mem_dm_req), .dmem_rdy(dmem_rdy),
        .imem_rdy(imem_rdy), .wb_hlt(wb_hlt), .stat_clr(stat_clr),
        .pc_we(pc_we), .pc_sel_alt(pc_sel_alt), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
        .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .halted(halted),
        .stall_cnt(stall_cnt), .mem_err(mem_err)
    );

    task automatic idle;
        id_rs = 4'd0; id_rt = 4'd0; ex_wr_reg = 4'd0;
        id_rs_vld = 1'b0; id_rt_vld = 1'b0; id_hlt = 1'b0;
        ex_dm_rd_en = 1'b0; ex_rf_we = 1'b0; mem_take_br = 1'b0;
        mem_dm_req = 1'b0; dmem_rdy = 1'b1; imem_rdy = 1'b1;
        wb_hlt = 1'b0; stat_clr = 1'b0;
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++; if (ctl !== C_FRZ) begin n_fail++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_FRZ); end
        n_chk++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
        n_chk++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL reset_mem_err got=%b exp=0", mem_err); end
        cyc(); rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (ctl !== C_NORM) begin n_fail++; $display("FAIL post_reset_ctl got=%b exp=%b", ctl, C_NORM); end
    endtask

    task automatic test_load_use;
        cyc(); ex_dm_rd_en = 1'b1; ex_rf_we = 1'b1; ex_wr_reg = 4'd3; id_rs = 4'd3; id_rs_vld = 1'b1;
        @(negedge clk);
        n_chk++; if (ctl !== C_LU) begin n_fail++; $display("FAIL lu_rs_ctl got=%b exp=%b", ctl, C_LU); end
        cyc(); idle();
        @(negedge clk);
        n_chk++; if (ctl !== C_NORM) begin n_fail++; $display("FAIL lu_after_ctl got=%b exp=%b", ctl, C_NORM); end
        n_chk++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
        cyc(); ex_dm_rd_en = 1'b1; ex_rf_we = 1'b1; ex_wr_reg = 4'd5; id_rs = 4'd2; id_rs_vld = 1'b1;
        id_rt = 4'd5; id_rt_vld = 1'b1;
        @(negedge clk);
        n_chk++; if (ctl !== C_LU) begin n_fail++; $display("FAIL lu_rt_ctl got=%b exp=%b", ctl, C_LU); end
        cyc(); id_rt_vld = 1'b0;
        @(negedge clk);
        n_chk++; if (ctl !== C_NORM) begin n_fail++; $display("FAIL lu_rt_invalid_ctl got=%b exp=%b", ctl, C_NORM); end
        cyc(); id_rt_vld = 1'b1; ex_rf_we = 1'b0;
        @(negedge clk);
        n_chk++; if (ctl !== C_NORM) begin n_fail++; $display("FAIL lu_no_rfwe_ctl got=%b exp=%b", ctl, C_NORM); end
        cyc(); idle(); ex_dm_rd_en = 1'b1; ex_rf_we = 1'b1; ex_wr_reg = 4'd0; id_rs_vld = 1'b1; id_rt_vld = 1'b1;
        @(negedge clk);
        n_chk++; if (ctl !== C_NORM) begin n_fail++; $display("FAIL lu_r0_ctl got=%b exp=%b", ctl, C_NORM); end
        n_chk++; if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL lu_r0_stall_cnt got=%0d exp=2", stall_cnt); end
    endtask

    task automatic test_branch;
        cyc(); idle(); mem_take_br = 1'b1;
        @(negedge clk);
        n_chk++; if (ctl !== C_BR) begin n_fail++; $display("FAIL br_ctl got=%b exp=%b", ctl, C_BR); end
        cyc(); ex_dm_rd_en = 1'b1; ex_rf_we = 1'b1; ex_wr_reg = 4'd7; id_rs = 4'd7; id_rs_vld = 1'b1; imem_rdy = 1'b0;
        @(negedge clk);
        n_chk++; if (ctl !== C_BR) begin n_fail++; $display("FAIL br_over_lu_ctl got=%b exp=%b", ctl, C_BR); end
        cyc(); idle();
        @(negedge clk);
        n_chk++; if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL br_stall_cnt got=%0d exp=2", stall_cnt); end
    endtask

    task automatic test_imem_wait;
        cyc(); imem_rdy = 1'b0; id_hlt = 1'b1;
        @(negedge clk);
        n_chk++; if (ctl !== C_IFW) begin n_fail++; $display("FAIL imem_ctl got=%b exp=%b", ctl, C_IFW); end
        cyc(); idle();
        @(negedge clk);
        n_chk++; if (ctl !== C_NORM) begin n_fail++; $display("FAIL imem_no_drain_ctl got=%b exp=%b", ctl, C_NORM); end
        n_chk++; if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL imem_stall_cnt got=%0d exp=3", stall_cnt); end
    endtask

    task automatic test_dmem_wait;
        cyc(); stat_clr = 1'b1;
        cyc(); stat_clr = 1'b0; mem_dm_req = 1'b1; dmem_rdy = 1'b0; mem_take_br = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++; if (ctl !== C_FRZ) begin n_fail++; $display("FAIL dm_wait_ctl cyc=%0d got=%b exp=%b", i, ctl, C_FRZ); end
            cyc();
        end
        dmem_rdy = 1'b1;
        @(negedge clk);
        n_chk++; if (ctl !== C_BR) begin n_fail++; $display("FAIL dm_done_br_ctl got=%b exp=%b", ctl, C_BR); end
        cyc(); idle();
        @(negedge clk);
        n_chk++; if (ctl !== C_NORM) begin n_fail++; $display("FAIL dm_after_ctl got=%b exp=%b", ctl, C_NORM); end
        n_chk++; if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL dm_stall_cnt got=%0d exp=3", stall_cnt); end
    endtask

    task automatic test_timeout;
        cyc(); mem_dm_req = 1'b1; dmem_rdy = 1'b0;
        for (int i = 0; i < 66; i++) begin
            if (i == 60) begin
                @(negedge clk);
                n_chk++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL to_early_mem_err got=%b exp=0", mem_err); end
            end
            cyc();
        end
        idle();
        @(negedge clk);
        n_chk++; if (mem_err !== 1'b1) begin n_fail++; $display("FAIL to_mem_err got=%b exp=1", mem_err); end
        n_chk++; if (stall_cnt !== 16'd69) begin n_fail++; $display("FAIL to_stall_cnt got=%0d exp=69", stall_cnt); end
        repeat (3) cyc();
        @(negedge clk);
        n_chk++; if (mem_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky_mem_err got=%b exp=1", mem_err); end
        cyc(); stat_clr = 1'b1;
        cyc(); stat_clr = 1'b0;
        @(negedge clk);
        n_chk++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL clr_mem_err got=%b exp=0", mem_err); end
        n_chk++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL clr_stall_cnt got=%0d exp=0", stall_cnt); end
    endtask

    task automatic test_halt;
        cyc(); id_hlt = 1'b1;
        @(negedge clk);
        n_chk++; if (ctl !== C_IFW) begin n_fail++; $display("FAIL hlt_run_ctl got=%b exp=%b", ctl, C_IFW); end
        cyc(); id_hlt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wb_hlt = (i == 2) ? 1'b1 : 1'b0;
            @(negedge clk);
            n_chk++; if (ctl !== C_IFW) begin n_fail++; $display("FAIL drain_ctl cyc=%0d got=%b exp=%b", i, ctl, C_IFW); end
            cyc();
        end
        wb_hlt = 1'b0;
        @(negedge clk);
        n_chk++; if (ctl !== C_HLT) begin n_fail++; $display("FAIL halted_ctl got=%b exp=%b", ctl, C_HLT); end
        n_chk++; if (stall_cnt !== 16'd4) begin n_fail++; $display("FAIL halt_stall_cnt got=%0d exp=4", stall_cnt); end
        cyc(); mem_take_br = 1'b1; id_hlt = 1'b1; imem_rdy = 1'b0;
        @(negedge clk);
        n_chk++; if (ctl !== C_HLT) begin n_fail++; $display("FAIL halted_terminal_ctl got=%b exp=%b", ctl, C_HLT); end
        cyc(); idle();
        @(negedge clk);
        n_chk++; if (stall_cnt !== 16'd4) begin n_fail++; $display("FAIL halted_no_count got=%0d exp=4", stall_cnt); end
        cyc(); rst_n = 1'b0;
        @(negedge clk);
        n_chk++; if (ctl !== C_FRZ) begin n_fail++; $display("FAIL halted_reset_ctl got=%b exp=%b", ctl, C_FRZ); end
        cyc(); rst_n = 1'b1;
    endtask

    task automatic test_drain_branch;
        cyc(); id_hlt = 1'b1;
        cyc(); id_hlt = 1'b0;
        @(negedge clk);
        n_chk++; if (ctl !== C_IFW) begin n_fail++; $display("FAIL db_drain_ctl got=%b exp=%b", ctl, C_IFW); end
        cyc(); mem_take_br = 1'b1;
        @(negedge clk);
        n_chk++; if (ctl !== C_BR) begin n_fail++; $display("FAIL db_br_ctl got=%b exp=%b", ctl, C_BR); end
        cyc(); idle();
        @(negedge clk);
        n_chk++; if (ctl !== C_NORM) begin n_fail++; $display("FAIL db_run_ctl got=%b exp=%b", ctl, C_NORM); end
        n_chk++; if (stall_cnt !== 16'd2) begin n_fail++; $display("FAIL db_stall_cnt got=%0d exp=2", stall_cnt); end
    endtask

    task automatic test_reset_mid_drain;
        cyc(); id_hlt = 1'b1;
        cyc(); id_hlt = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        n_chk++; if (stall_cnt !== 16'd5) begin n_fail++; $display("FAIL rmd_pre_stall_cnt got=%0d exp=5", stall_cnt); end
        n_chk++; if (ctl !== C_IFW) begin n_fail++; $display("FAIL rmd_pre_ctl got=%b exp=%b", ctl, C_IFW); end
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (ctl !== C_FRZ) begin n_fail++; $display("FAIL rmd_ctl got=%b exp=%b", ctl, C_FRZ); end
        n_chk++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rmd_stall_cnt got=%0d exp=0", stall_cnt); end
        cyc(); rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (ctl !== C_NORM) begin n_fail++; $display("FAIL rmd_run_ctl got=%b exp=%b", ctl, C_NORM); end
        n_chk++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rmd_post_stall_cnt got=%0d exp=0", stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_imem_wait();
        test_dmem_wait();
        test_timeout();
        test_halt();
        test_drain_branch();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
